mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port between the IF stage (instruction fetch)
//  and the MEM stage (load/store).

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 63 ++++++
 rtl/mem_arb_grant.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
//------------------------------------------------------------------------------
// pipeline_pkg : FSM state encodings and request-owner codes for the memory
//                port arbiter.
// Revision     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
//------------------------------------------------------------------------------
// mem_port_arbiter_if : fetch, data and memory-side handshake bundle.
// Revision            : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import pipeline_pkg::*;

  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;

  logic                dm_req_valid;
  logic [ADDR_W-1:0]   dm_req_addr;
  logic                dm_req_we;
  logic [DATA_W/8-1:0] dm_req_wmask;
  logic [DATA_W-1:0]   dm_req_wdata;
  logic                dm_req_ready;
  logic                dm_rsp_valid;
  logic [DATA_W-1:0]   dm_rsp_rdata;

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic                mem_req_we;
  logic [DATA_W/8-1:0] mem_req_wmask;
  logic [DATA_W-1:0]   mem_req_wdata;
  logic                mem_rsp_valid;
  logic [DATA_W-1:0]   mem_rsp_data;

  logic busy;

  // Arbiter side.
  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  dm_req_valid, dm_req_addr, dm_req_we, dm_req_wmask, dm_req_wdata,
    output dm_req_ready, dm_rsp_valid, dm_rsp_rdata,
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wmask, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output busy
  );

  // Requester / memory side.
  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output dm_req_valid, dm_req_addr, dm_req_we, dm_req_wmask, dm_req_wdata,
    input  dm_req_ready, dm_rsp_valid, dm_rsp_rdata,
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wmask, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  busy
  );

endinterface

`default_nettype wire

// File: rtl/mem_arb_grant.sv
//------------------------------------------------------------------------------
// mem_arb_grant : winner select between fetch and data; data wins conflicts.
//                 MEM_ARB_FAIR_EN adds a data-streak counter that hands one
//                 conflict to fetch after MAX_DATA_STREAK data grants.
// Revision      : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arb_grant
  import pipeline_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic if_valid,
  input  logic dm_valid,
  output logic grant_if,
  output logic grant_dm
);

`ifdef MEM_ARB_FAIR_EN
  localparam int CNT_W = $clog2(MAX_DATA_STREAK + 1);

  logic [CNT_W-1:0] r_streak;
  logic             w_fetch_turn;

  assign w_fetch_turn = (r_streak == CNT_W'(MAX_DATA_STREAK));
  assign grant_dm     = enable & dm_valid & ~(if_valid & w_fetch_turn);
  assign grant_if     = enable & if_valid & ~grant_dm;

  // Only data grants that bypassed a waiting fetch extend the streak.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= '0;
    end else if (grant_if) begin
      r_streak <= '0;
    end else if (grant_dm) begin
      r_streak <= if_valid ? r_streak + CNT_W'(1) : '0;
    end
  end
`else
  logic                                   w_unused_clk_rst;
  logic [$clog2(MAX_DATA_STREAK + 1)-1:0] w_unused_streak;

  assign w_unused_clk_rst = clk ^ rst;
  assign w_unused_streak  = '0;
  assign grant_dm         = enable & dm_valid;
  assign grant_if         = enable & if_valid & ~dm_valid;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// mem_port_arbiter : shares one memory port between instruction fetch and the
//                    load/store stage, one transaction in flight at a time.
//                    Optional fairness: define MEM_ARB_FAIR_EN.
// Revision         : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import pipeline_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  logic                r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W/8-1:0] r_wmask;
  logic [DATA_W-1:0]   r_wdata;

  logic              r_if_rsp_valid;
  logic [DATA_W-1:0] r_if_rsp_data;
  logic              r_dm_rsp_valid;
  logic [DATA_W-1:0] r_dm_rsp_rdata;

  logic w_grant_if;
  logic w_grant_dm;
  logic w_accept;
  logic w_rsp_fire;
  logic w_store;

  // Reset gates the grant so ready reads 0 for the whole reset window.
  mem_arb_grant #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_grant (
    .clk     (clk),
    .rst     (rst),
    .enable  ((r_state == ST_IDLE) & ~rst),
    .if_valid(bus.if_req_valid),
    .dm_valid(bus.dm_req_valid),
    .grant_if(w_grant_if),
    .grant_dm(w_grant_dm)
  );

  assign w_accept   = w_grant_if | w_grant_dm;
  assign w_store    = w_grant_dm & bus.dm_req_we;
  assign w_rsp_fire = (r_state == ST_WAIT) & bus.mem_rsp_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)           w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (bus.mem_req_ready)  w_state_nxt = ST_WAIT;
      ST_WAIT:  if (bus.mem_rsp_valid)  w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= OWN_IF;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wmask <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_owner <= w_grant_dm ? OWN_DM : OWN_IF;
      r_addr  <= w_grant_dm ? bus.dm_req_addr : bus.if_req_addr;
      r_we    <= w_store;
      r_wmask <= w_store ? bus.dm_req_wmask : '0;
      r_wdata <= w_grant_dm ? bus.dm_req_wdata : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_rsp_valid <= 1'b0;
      r_if_rsp_data  <= '0;
      r_dm_rsp_valid <= 1'b0;
      r_dm_rsp_rdata <= '0;
    end else begin
      r_if_rsp_valid <= w_rsp_fire & (r_owner == OWN_IF);
      r_dm_rsp_valid <= w_rsp_fire & (r_owner == OWN_DM);
      if (w_rsp_fire && (r_owner == OWN_IF)) begin
        r_if_rsp_data <= bus.mem_rsp_data;
      end
      // A store ack carries no data back to the requester.
      if (w_rsp_fire && (r_owner == OWN_DM)) begin
        r_dm_rsp_rdata <= r_we ? '0 : bus.mem_rsp_data;
      end
    end
  end

  assign bus.if_req_ready  = w_grant_if;
  assign bus.dm_req_ready  = w_grant_dm;
  assign bus.if_rsp_valid  = r_if_rsp_valid;
  assign bus.if_rsp_data   = r_if_rsp_data;
  assign bus.dm_rsp_valid  = r_dm_rsp_valid;
  assign bus.dm_rsp_rdata  = r_dm_rsp_rdata;
  assign bus.mem_req_valid = (r_state == ST_ISSUE);
  assign bus.mem_req_addr  = r_addr;
  assign bus.mem_req_we    = r_we;
  assign bus.mem_req_wmask = r_wmask;
  assign bus.mem_req_wdata = r_wdata;
  assign bus.busy          = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_port_arbiter : directed scenarios plus randomized traffic checked
//                       against a transaction-level model of the arbiter.
// Revision            : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  localparam int ADDR_W          = 32;
  localparam int DATA_W          = 32;
  localparam int MAX_DATA_STREAK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  int checks   = 0;
  int failures = 0;

  int cfg_stall = 0;
  int cfg_delay = 0;
  int inj_req   = 0;

  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_arr [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_arr.exists(a) ? ref_arr[a] : init_word(a);
  endfunction

  // Memory model: stall before ready, delay after handshake, optional spurious responses.
  initial begin : responder
    int seen, cnt, inj_done;
    bit pending, hs, w;
    logic [31:0] a, wd, pdata, old_w;
    logic [3:0] m;
    seen = 0; cnt = 0; inj_done = 0; pending = 0; pdata = '0;
    bif.mem_req_ready = 1'b0;
    bif.mem_rsp_valid = 1'b0;
    bif.mem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      hs = bif.mem_req_valid && bif.mem_req_ready;
      a = bif.mem_req_addr; w = bif.mem_req_we; m = bif.mem_req_wmask; wd = bif.mem_req_wdata;
      #1;
      bif.mem_rsp_valid = 1'b0;
      if (hs) begin
        pending = 1; cnt = cfg_delay;
        old_w = mem_arr.exists(a) ? mem_arr[a] : init_word(a);
        if (w) begin
          mem_arr[a] = merge(old_w, wd, m);
          pdata = $urandom();
        end else begin
          pdata = old_w;
        end
      end
      if (pending) begin
        if (cnt == 0) begin
          bif.mem_rsp_valid = 1'b1; bif.mem_rsp_data = pdata; pending = 0;
        end else begin
          cnt--;
        end
      end else if (inj_req != inj_done) begin
        bif.mem_rsp_valid = 1'b1; bif.mem_rsp_data = $urandom(); inj_done++;
      end
      if (bif.mem_req_valid) begin
        if (seen < cfg_stall) begin bif.mem_req_ready = 1'b0; seen++; end
        else bif.mem_req_ready = 1'b1;
      end else begin
        seen = 0; bif.mem_req_ready = (cfg_stall == 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bif.if_req_valid = 1'b0; bif.if_req_addr = '0;
    bif.dm_req_valid = 1'b0; bif.dm_req_addr = '0; bif.dm_req_we = 1'b0;
    bif.dm_req_wmask = '0;   bif.dm_req_wdata = '0;
  endtask

  task automatic set_mem(input int stall, input int delay);
    @(negedge clk); cfg_stall = stall; cfg_delay = delay; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({bif.if_req_ready, bif.dm_req_ready} !== 2'b00) begin failures++;
      $display("FAIL reset_ready: got %b expected 00", {bif.if_req_ready, bif.dm_req_ready}); end
    checks++; if ({bif.if_rsp_valid, bif.dm_rsp_valid, bif.mem_req_valid, bif.busy} !== 4'b0) begin failures++;
      $display("FAIL reset_valids: got %b expected 0000", {bif.if_rsp_valid, bif.dm_rsp_valid, bif.mem_req_valid, bif.busy}); end
    checks++; if ({bif.mem_req_addr, bif.mem_req_we, bif.mem_req_wmask, bif.mem_req_wdata} !== '0) begin failures++;
      $display("FAIL reset_mem_fields: got addr=%0h we=%b mask=%b wdata=%0h expected all 0",
               bif.mem_req_addr, bif.mem_req_we, bif.mem_req_wmask, bif.mem_req_wdata); end
    checks++; if ({bif.if_rsp_data, bif.dm_rsp_rdata} !== '0) begin failures++;
      $display("FAIL reset_rsp_data: got %0h/%0h expected 0/0", bif.if_rsp_data, bif.dm_rsp_rdata); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_fetch_only();
    bif.if_req_valid = 1'b1; bif.if_req_addr = 32'h100;
    @(negedge clk);
    checks++; if ({bif.if_req_ready, bif.dm_req_ready} !== 2'b10) begin failures++;
      $display("FAIL fetch_accept: got %b expected 10", {bif.if_req_ready, bif.dm_req_ready}); end
    tick(); bif.if_req_valid = 1'b0;
    @(negedge clk);
    checks++; if ({bif.mem_req_valid, bif.mem_req_addr, bif.mem_req_we, bif.mem_req_wmask} !== {1'b1, 32'h100, 1'b0, 4'h0}) begin failures++;
      $display("FAIL fetch_issue: got v=%b addr=%0h we=%b mask=%b expected v=1 addr=100 we=0 mask=0",
               bif.mem_req_valid, bif.mem_req_addr, bif.mem_req_we, bif.mem_req_wmask); end
    tick(); @(negedge clk);
    checks++; if ({bif.if_rsp_valid, bif.busy} !== 2'b01) begin failures++;
      $display("FAIL fetch_wait: got rsp/busy=%b expected 01", {bif.if_rsp_valid, bif.busy}); end
    tick(); @(negedge clk);
    checks++; if ({bif.if_rsp_valid, bif.if_rsp_data, bif.dm_rsp_valid, bif.busy} !== {1'b1, 32'h13, 1'b0, 1'b0}) begin failures++;
      $display("FAIL fetch_rsp: got v=%b data=%0h dmv=%b busy=%b expected v=1 data=13 dmv=0 busy=0",
               bif.if_rsp_valid, bif.if_rsp_data, bif.dm_rsp_valid, bif.busy); end
    tick();
  endtask

  task automatic test_conflict();
    bif.if_req_valid = 1'b1; bif.if_req_addr = 32'h300;
    bif.dm_req_valid = 1'b1; bif.dm_req_addr = 32'h200; bif.dm_req_we = 1'b0;
    @(negedge clk);
    checks++; if ({bif.if_req_ready, bif.dm_req_ready} !== 2'b01) begin failures++;
      $display("FAIL conflict_priority: got if/dm ready=%b expected 01", {bif.if_req_ready, bif.dm_req_ready}); end
    tick(); bif.dm_req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (bif.if_req_ready !== 1'b0) begin failures++;
        $display("FAIL conflict_no_accept_busy: got %b expected 0", bif.if_req_ready); end
      tick();
    end
    @(negedge clk);
    checks++; if ({bif.dm_rsp_valid, bif.dm_rsp_rdata, bif.if_req_ready} !== {1'b1, init_word(32'h200), 1'b1}) begin failures++;
      $display("FAIL conflict_pulse_cycle: got dmv=%b rdata=%0h if_ready=%b expected 1 %0h 1",
               bif.dm_rsp_valid, bif.dm_rsp_rdata, bif.if_req_ready, init_word(32'h200)); end
    tick(); bif.if_req_valid = 1'b0;
    tick(); tick(); @(negedge clk);
    checks++; if ({bif.if_rsp_valid, bif.if_rsp_data, bif.dm_rsp_valid} !== {1'b1, init_word(32'h300), 1'b0}) begin failures++;
      $display("FAIL conflict_fetch_rsp: got v=%b data=%0h dmv=%b expected 1 %0h 0",
               bif.if_rsp_valid, bif.if_rsp_data, bif.dm_rsp_valid, init_word(32'h300)); end
    tick();
  endtask

  task automatic test_store_stall();
    logic [68:0] exp_f;
    set_mem(5, 0);
    bif.dm_req_valid = 1'b1; bif.dm_req_addr = 32'h204; bif.dm_req_we = 1'b1;
    bif.dm_req_wmask = 4'b0011; bif.dm_req_wdata = 32'hDEAD_BEEF;
    ref_arr[32'h204] = merge(ref_rd(32'h204), 32'hDEAD_BEEF, 4'b0011);
    exp_f = {1'b1, 32'h204, 4'b0011, 32'hDEAD_BEEF};
    @(negedge clk);
    checks++; if (bif.dm_req_ready !== 1'b1) begin failures++;
      $display("FAIL store_accept: got %b expected 1", bif.dm_req_ready); end
    tick();
    bif.dm_req_valid = 1'b0; bif.dm_req_addr = $urandom(); bif.dm_req_we = 1'b0;
    bif.dm_req_wmask = 4'hF; bif.dm_req_wdata = $urandom();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if ({bif.mem_req_valid, bif.mem_req_we, bif.mem_req_addr, bif.mem_req_wmask, bif.mem_req_wdata} !== {1'b1, exp_f}) begin failures++;
        $display("FAIL store_stall_stable[%0d]: got v=%b we=%b addr=%0h mask=%b wdata=%0h expected 1 1 204 0011 deadbeef",
                 i, bif.mem_req_valid, bif.mem_req_we, bif.mem_req_addr, bif.mem_req_wmask, bif.mem_req_wdata); end
      tick();
    end
    @(negedge clk);
    checks++; if ({bif.mem_req_valid, bif.dm_rsp_valid} !== 2'b00) begin failures++;
      $display("FAIL store_wait: got memv/dmv=%b expected 00", {bif.mem_req_valid, bif.dm_rsp_valid}); end
    tick(); @(negedge clk);
    checks++; if ({bif.dm_rsp_valid, bif.dm_rsp_rdata, bif.if_rsp_valid} !== {1'b1, 32'h0, 1'b0}) begin failures++;
      $display("FAIL store_ack: got v=%b rdata=%0h ifv=%b expected 1 0 0",
               bif.dm_rsp_valid, bif.dm_rsp_rdata, bif.if_rsp_valid); end
    set_mem(0, 0);
  endtask

  task automatic test_reset_in_wait();
    set_mem(0, 3);
    bif.if_req_valid = 1'b1; bif.if_req_addr = 32'h400;
    tick(); bif.if_req_valid = 1'b0;
    tick();
    checks++; if (bif.busy !== 1'b1) begin failures++;
      $display("FAIL rstwait_busy_before: got %b expected 1", bif.busy); end
    rst = 1'b1; #1;
    checks++; if ({bif.busy, bif.mem_req_valid, bif.if_req_ready, bif.dm_req_ready, bif.if_rsp_valid, bif.dm_rsp_valid} !== 6'b0) begin failures++;
      $display("FAIL rstwait_outputs: got %b expected 000000",
               {bif.busy, bif.mem_req_valid, bif.if_req_ready, bif.dm_req_ready, bif.if_rsp_valid, bif.dm_rsp_valid}); end
    checks++; if ({bif.mem_req_addr, bif.mem_req_we, bif.mem_req_wmask, bif.mem_req_wdata} !== '0) begin failures++;
      $display("FAIL rstwait_fields: got addr=%0h expected 0", bif.mem_req_addr); end
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({bif.if_rsp_valid, bif.dm_rsp_valid, bif.busy} !== 3'b000) begin failures++;
        $display("FAIL rstwait_late_rsp[%0d]: got ifv/dmv/busy=%b expected 000",
                 i, {bif.if_rsp_valid, bif.dm_rsp_valid, bif.busy}); end
      tick();
    end
    set_mem(0, 0);
    bif.if_req_valid = 1'b1; bif.if_req_addr = 32'h100;
    tick(); bif.if_req_valid = 1'b0;
    tick(); tick(); @(negedge clk);
    checks++; if ({bif.if_rsp_valid, bif.if_rsp_data} !== {1'b1, 32'h13}) begin failures++;
      $display("FAIL rstwait_recover: got v=%b data=%0h expected 1 13", bif.if_rsp_valid, bif.if_rsp_data); end
    tick();
  endtask

  task automatic test_spurious();
    @(negedge clk); inj_req++;
    tick(); @(negedge clk);
    checks++; if ({bif.busy, bif.if_rsp_valid, bif.dm_rsp_valid} !== 3'b000) begin failures++;
      $display("FAIL spurious_same: got busy/ifv/dmv=%b expected 000", {bif.busy, bif.if_rsp_valid, bif.dm_rsp_valid}); end
    tick(); @(negedge clk);
    checks++; if ({bif.busy, bif.if_rsp_valid, bif.dm_rsp_valid} !== 3'b000) begin failures++;
      $display("FAIL spurious_next: got busy/ifv/dmv=%b expected 000", {bif.busy, bif.if_rsp_valid, bif.dm_rsp_valid}); end
    tick();
  endtask

  task automatic test_back_to_back();
    byte got [10];
    byte exp;
    int  ng;
    ng = 0;
    bif.if_req_valid = 1'b1; bif.if_req_addr = 32'h2000;
    bif.dm_req_valid = 1'b1; bif.dm_req_addr = 32'h3000; bif.dm_req_we = 1'b0;
    for (int t = 0; t < 60 && ng < 10; t++) begin
      @(negedge clk);
      checks++; if (bif.if_req_ready && bif.dm_req_ready) begin failures++;
        $display("FAIL b2b_double_grant: got 11 expected at most one"); end
      if (bif.dm_req_ready)      begin got[ng] = "D"; ng++; end
      else if (bif.if_req_ready) begin got[ng] = "I"; ng++; end
      tick();
      bif.if_req_addr = 32'h2000 | {$urandom_range(0, 63), 2'b00};
      bif.dm_req_addr = 32'h3000 | {$urandom_range(0, 63), 2'b00};
    end
    checks++; if (ng !== 10) begin failures++;
      $display("FAIL b2b_grant_count: got %0d expected 10", ng); end
    for (int i = 0; i < ng; i++) begin
`ifdef MEM_ARB_FAIR_EN
      exp = ((i % (MAX_DATA_STREAK + 1)) == MAX_DATA_STREAK) ? "I" : "D";
`else
      exp = "D";
`endif
      checks++; if (got[i] !== exp) begin failures++;
        $display("FAIL b2b_grant[%0d]: got %c expected %c", i, got[i], exp); end
    end
    bif.if_req_valid = 1'b0; bif.dm_req_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_random(input int ncyc, input int stall, input int delay);
    int lat, t, acc_t, streak;
    bit obusy, own_dm, ipend, dpend, pulse, gi, gd, exp_mv;
    logic [31:0] ea, ewd, edata;
    logic ewe;
    logic [3:0] em;
    set_mem(stall, delay);
    lat = 3 + stall + delay;
    t = 0; acc_t = 0; streak = 0; obusy = 0; own_dm = 0; ipend = 0; dpend = 0;
    ea = '0; ewd = '0; edata = '0; ewe = 0; em = '0;
    while (t < ncyc || obusy || ipend || dpend) begin
      if (t > ncyc + 200) begin
        checks++; failures++;
        $display("FAIL random_timeout: got t=%0d expected drain within %0d cycles", t, ncyc + 200);
        break;
      end
      if (!ipend && t < ncyc && $urandom_range(0, 2) != 0) begin
        ipend = 1; bif.if_req_valid = 1'b1;
        bif.if_req_addr = 32'h1000 | {$urandom_range(0, 15), 2'b00};
      end
      if (!dpend && t < ncyc && $urandom_range(0, 2) != 0) begin
        dpend = 1; bif.dm_req_valid = 1'b1;
        bif.dm_req_addr  = 32'h1000 | {$urandom_range(0, 15), 2'b00};
        bif.dm_req_we    = $urandom_range(0, 1);
        bif.dm_req_wmask = $urandom_range(0, 15);
        bif.dm_req_wdata = $urandom();
      end
      @(negedge clk);
      pulse = obusy && (t == acc_t + lat);
      checks++; if ({bif.if_rsp_valid, bif.dm_rsp_valid} !== {pulse && !own_dm, pulse && own_dm}) begin failures++;
        $display("FAIL random_rsp_valid t=%0d: got if/dm=%b expected %b", t,
                 {bif.if_rsp_valid, bif.dm_rsp_valid}, {pulse && !own_dm, pulse && own_dm}); end
      if (pulse) begin
        checks++; if ((own_dm ? bif.dm_rsp_rdata : bif.if_rsp_data) !== edata) begin failures++;
          $display("FAIL random_rsp_data t=%0d: got %0h expected %0h", t,
                   own_dm ? bif.dm_rsp_rdata : bif.if_rsp_data, edata); end
        obusy = 0;
      end
      exp_mv = obusy && (t >= acc_t + 1) && (t <= acc_t + 1 + stall);
      checks++; if (bif.mem_req_valid !== exp_mv) begin failures++;
        $display("FAIL random_mem_valid t=%0d: got %b expected %b", t, bif.mem_req_valid, exp_mv); end
      if (exp_mv) begin
        checks++; if ({bif.mem_req_addr, bif.mem_req_we, bif.mem_req_wmask} !== {ea, ewe, em} ||
                      (ewe && bif.mem_req_wdata !== ewd)) begin failures++;
          $display("FAIL random_mem_fields t=%0d: got addr=%0h we=%b mask=%b wdata=%0h expected %0h %b %b %0h",
                   t, bif.mem_req_addr, bif.mem_req_we, bif.mem_req_wmask, bif.mem_req_wdata, ea, ewe, em, ewd); end
      end
      gi = 0; gd = 0;
      if (!obusy) begin
        if (dpend && ipend) begin
`ifdef MEM_ARB_FAIR_EN
          if (streak >= MAX_DATA_STREAK) gi = 1; else gd = 1;
`else
          gd = 1;
`endif
        end else if (dpend) gd = 1;
        else if (ipend) gi = 1;
      end
      checks++; if ({bif.if_req_ready, bif.dm_req_ready} !== {gi, gd}) begin failures++;
        $display("FAIL random_grant t=%0d: got if/dm ready=%b expected %b", t,
                 {bif.if_req_ready, bif.dm_req_ready}, {gi, gd}); end
      if (gi || gd) begin
        acc_t = t; obusy = 1; own_dm = gd;
        ea  = gd ? bif.dm_req_addr : bif.if_req_addr;
        ewe = gd && bif.dm_req_we;
        em  = ewe ? bif.dm_req_wmask : 4'h0;
        ewd = bif.dm_req_wdata;
        edata = ewe ? 32'h0 : ref_rd(ea);
        if (ewe) ref_arr[ea] = merge(ref_rd(ea), ewd, em);
        if (gi) streak = 0;
        else if (ipend) streak++;
        else streak = 0;
      end
      tick();
      if (gi) begin ipend = 0; bif.if_req_valid = 1'b0; end
      if (gd) begin dpend = 0; bif.dm_req_valid = 1'b0; end
      t++;
    end
    set_mem(0, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_conflict();
    test_store_stall();
    test_reset_in_wait();
    test_spurious();
    test_back_to_back();
    test_random(300, 0, 0);
    test_random(300, 2, 1);
    test_random(200, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
